// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pong_pkg
// Brief    : Shared game types and constants for the pong controller.
// Revision : 1.0
// ============================================================================
package pong_pkg;

    localparam int c_SCREEN_W    = 640;
    localparam int c_SCREEN_H    = 480;
    localparam int c_SCORE_W     = 4;
    localparam int c_FRAME_CNT_W = 7;
    localparam int c_STATE_W     = 3;

    localparam logic [c_STATE_W-1:0] c_ST_IDLE  = 3'd0;
    localparam logic [c_STATE_W-1:0] c_ST_SERVE = 3'd1;
    localparam logic [c_STATE_W-1:0] c_ST_PLAY  = 3'd2;
    localparam logic [c_STATE_W-1:0] c_ST_POINT = 3'd3;
    localparam logic [c_STATE_W-1:0] c_ST_OVER  = 3'd4;

    typedef enum logic [c_STATE_W-1:0] {
        ST_IDLE  = c_ST_IDLE,
        ST_SERVE = c_ST_SERVE,
        ST_PLAY  = c_ST_PLAY,
        ST_POINT = c_ST_POINT,
        ST_OVER  = c_ST_OVER
    } game_state_t;

    localparam logic [1:0] c_WIN_NONE  = 2'b00;
    localparam logic [1:0] c_WIN_LEFT  = 2'b01;
    localparam logic [1:0] c_WIN_RIGHT = 2'b10;

    typedef logic [c_SCORE_W-1:0] score_t;

    // Saturating increment: a score never wraps back to zero.
    function automatic score_t score_inc(input score_t s);
        return (s == '1) ? s : s + score_t'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/edge_detect.sv
`default_nettype none
// ============================================================================
// Module   : edge_detect
// Brief    : Registered single-cycle edge pulse with selectable polarity.
// Revision : 1.0
// ============================================================================
module edge_detect #(
    parameter bit RISING       = 1'b1,
    parameter bit RESET_VAL    = 1'b0,
    parameter bit ARM_AT_RESET = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_sig,
    output logic o_pulse
);

    logic r_sig;
    logic r_prev;
    logic r_armed;
    logic w_edge;

    // Unarmed detectors ignore an input already active when reset releases;
    // they arm once the input is seen at its idle level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sig   <= RESET_VAL;
            r_prev  <= RESET_VAL;
            r_armed <= ARM_AT_RESET;
        end else begin
            r_sig  <= i_sig;
            r_prev <= r_sig;
            if (i_sig != RISING) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign w_edge  = RISING ? (r_sig & ~r_prev) : (~r_sig & r_prev);
    assign o_pulse = r_armed & w_edge;

endmodule
`default_nettype wire

// File: rtl/game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : game_ctrl
// Brief    : Pong game sequencer: serve, play, point pause, game over.
// Revision : 1.0
// ============================================================================
module game_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 90,
    parameter int LEFT_GOAL    = 10,
    parameter int RIGHT_GOAL   = c_SCREEN_W - 10
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 vsync,
    input  logic                 start,
    input  logic [9:0]           ball_x_pos,
    output logic                 ball_run,
    output logic                 ball_serve,
    output logic                 serve_dir,
    output logic [c_SCORE_W-1:0] score_left,
    output logic [c_SCORE_W-1:0] score_right,
    output logic [1:0]           winner,
    output logic [c_STATE_W-1:0] state
);

    localparam logic [c_FRAME_CNT_W-1:0] c_SERVE_LAST = c_FRAME_CNT_W'(SERVE_FRAMES - 1);
    localparam logic [c_FRAME_CNT_W-1:0] c_POINT_LAST = c_FRAME_CNT_W'(POINT_FRAMES - 1);
    localparam logic [c_FRAME_CNT_W-1:0] c_CNT_ONE    = c_FRAME_CNT_W'(1);
    localparam logic [9:0]               c_LEFT_GOAL  = 10'(LEFT_GOAL);
    localparam logic [9:0]               c_RIGHT_GOAL = 10'(RIGHT_GOAL);
    localparam score_t                   c_WIN        = score_t'(WIN_SCORE);

    logic w_frame_tick;
    logic w_start_rise;

    game_state_t              r_state;
    logic [c_FRAME_CNT_W-1:0] r_frame_cnt;
    logic                     r_ball_run;
    logic                     r_ball_serve;
    logic                     r_serve_dir;
    score_t                   r_score_left;
    score_t                   r_score_right;
    logic [1:0]               r_winner;

    edge_detect #(
        .RISING       (1'b0),
        .RESET_VAL    (1'b1),
        .ARM_AT_RESET (1'b1)
    ) u_vsync_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .i_sig   (vsync),
        .o_pulse (w_frame_tick)
    );

    edge_detect #(
        .RISING       (1'b1),
        .RESET_VAL    (1'b0),
        .ARM_AT_RESET (1'b0)
    ) u_start_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .i_sig   (start),
        .o_pulse (w_start_rise)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_frame_cnt   <= '0;
            r_ball_run    <= 1'b0;
            r_ball_serve  <= 1'b0;
            r_serve_dir   <= 1'b0;
            r_score_left  <= '0;
            r_score_right <= '0;
            r_winner      <= c_WIN_NONE;
        end else begin
            r_ball_serve <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_score_left  <= '0;
                    r_score_right <= '0;
                    r_winner      <= c_WIN_NONE;
                    r_ball_run    <= 1'b0;
                    if (w_start_rise) begin
                        r_state      <= ST_SERVE;
                        r_serve_dir  <= 1'b0;
                        r_ball_serve <= 1'b1;
                        r_frame_cnt  <= '0;
                    end
                end

                ST_SERVE: begin
                    if (w_frame_tick) begin
                        if (r_frame_cnt == c_SERVE_LAST) begin
                            r_state     <= ST_PLAY;
                            r_ball_run  <= 1'b1;
                            r_frame_cnt <= '0;
                        end else begin
                            r_frame_cnt <= r_frame_cnt + c_CNT_ONE;
                        end
                    end
                end

                // Left miss is tested first so it wins if both goals are hit.
                ST_PLAY: begin
                    if (ball_x_pos <= c_LEFT_GOAL) begin
                        r_score_right <= score_inc(r_score_right);
                        r_serve_dir   <= 1'b0;
                        r_state       <= ST_POINT;
                        r_ball_run    <= 1'b0;
                        r_frame_cnt   <= '0;
                    end else if (ball_x_pos >= c_RIGHT_GOAL) begin
                        r_score_left <= score_inc(r_score_left);
                        r_serve_dir  <= 1'b1;
                        r_state      <= ST_POINT;
                        r_ball_run   <= 1'b0;
                        r_frame_cnt  <= '0;
                    end
                end

                ST_POINT: begin
                    if (w_frame_tick) begin
                        if (r_frame_cnt == c_POINT_LAST) begin
                            r_frame_cnt <= '0;
                            if (r_score_left == c_WIN) begin
                                r_state  <= ST_OVER;
                                r_winner <= c_WIN_LEFT;
                            end else if (r_score_right == c_WIN) begin
                                r_state  <= ST_OVER;
                                r_winner <= c_WIN_RIGHT;
                            end else begin
                                r_state      <= ST_SERVE;
                                r_ball_serve <= 1'b1;
                            end
                        end else begin
                            r_frame_cnt <= r_frame_cnt + c_CNT_ONE;
                        end
                    end
                end

                ST_OVER: begin
                    r_ball_run <= 1'b0;
                    if (w_start_rise) begin
                        r_score_left  <= '0;
                        r_score_right <= '0;
                        r_winner      <= c_WIN_NONE;
                        r_serve_dir   <= 1'b0;
                        r_state       <= ST_SERVE;
                        r_ball_serve  <= 1'b1;
                        r_frame_cnt   <= '0;
                    end
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_frame_cnt <= '0;
                    r_ball_run  <= 1'b0;
                end
            endcase
        end
    end

    assign ball_run    = r_ball_run;
    assign ball_serve  = r_ball_serve;
    assign serve_dir   = r_serve_dir;
    assign score_left  = r_score_left;
    assign score_right = r_score_right;
    assign winner      = r_winner;
    assign state       = r_state;

endmodule
`default_nettype wire

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter WIN_SCORE, default 7: points needed to win; range 1..15.
REQ-002 Parameter SERVE_FRAMES, default 60: frames ball is held at centre before play.
REQ-003 Parameter POINT_FRAMES, default 90: frames of pause after a point.
REQ-004 Parameter LEFT_GOAL, default 10: ball_x_pos at or below this is a left-side miss.
REQ-005 Parameter RIGHT_GOAL, default 630: ball_x_pos at or above this is a right-side miss.
REQ-006 clk  in  1  pixel clock (divided clock); the only clock.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 vsync  in  1  active-low vertical sync from the VGA counters; frame tick source.
REQ-009 start  in  1  player start button, level, synchronous to clk.
REQ-010 ball_x_pos  in  10  current ball centre x, unsigned.
REQ-011 ball_run  out  1  ball motion enable; high only in PLAY.
REQ-012 ball_serve  out  1  one-cycle pulse: ball re-centres.
REQ-013 serve_dir  out  1  0 = serve toward left player, 1 = toward right.
REQ-014 score_left  out  4  left player score.
REQ-015 score_right  out  4  right player score.
REQ-016 winner  out  2  00 none, 01 left, 10 right; 11 never driven.
REQ-017 state  out  3  current state encoding, for debug and display.

Function
REQ-018 frame_tick SHALL be a one-clk pulse on the cycle after vsync is sampled 1 then 0 (falling edge, registered).
REQ-019 start_rise SHALL be a one-clk pulse on a 0->1 transition of registered start.
REQ-020 States SHALL be IDLE, SERVE, PLAY, POINT, OVER; the state output shows the current state.
REQ-021 IDLE: scores 0, winner 00, ball_run 0; on start_rise -> SERVE, serve_dir 0.
REQ-022 Every entry into SERVE SHALL assert ball_serve for exactly one cycle (the first SERVE cycle) and clear the frame counter.
REQ-023 SERVE: count frame_tick; on the SERVE_FRAMES-th tick -> PLAY on the same edge.
REQ-024 PLAY: ball_run 1; ball_x_pos <= LEFT_GOAL -> score_right+1, serve_dir 0, -> POINT on the next edge (1-cycle latency).
REQ-025 PLAY: ball_x_pos >= RIGHT_GOAL -> score_left+1, serve_dir 1, -> POINT; if both conditions hold, the left-miss rule wins.
REQ-026 A score SHALL increment exactly once per PLAY->POINT transition and saturate at 15.
REQ-027 POINT: ball_run 0; count frame_tick; on the POINT_FRAMES-th tick -> OVER if either score equals WIN_SCORE, else -> SERVE.
REQ-028 OVER: winner set to the side whose score equals WIN_SCORE, held; ball_run 0; on start_rise, clear scores and winner, serve_dir 0 -> SERVE.
REQ-029 start SHALL be ignored in SERVE, PLAY and POINT.
REQ-030 The frame counter SHALL be 7 bits wide and clear on every state change; frame_tick has no effect in IDLE, PLAY or OVER.
REQ-031 All outputs SHALL be registered; no output depends combinationally on an input.

Reset
REQ-032 reset_n low SHALL immediately force IDLE, scores 0, winner 00, ball_run 0, ball_serve 0, serve_dir 0, frame counter 0 and edge-detect registers to 1 (vsync) and 0 (start), in any state including mid-POINT.
REQ-033 After reset release, start held high SHALL NOT produce start_rise until it drops low and rises again.

Structure
REQ-034 Package pong_pkg SHALL hold the game_state_t enum, screen width/height constants and score width.
REQ-035 The edge detector SHALL be one reusable sub-module, edge_detect (parameterised polarity), instanced for vsync and start.

Verification
REQ-036 Reset, start pulse -> ball_serve high 1 cycle, state SERVE; after 60 vsync falls -> PLAY, ball_run 1.
REQ-037 In PLAY drive ball_x_pos=5 -> next edge score_right=1, serve_dir 0, POINT; after 90 frames -> SERVE with ball_serve pulse.
REQ-038 Drive ball_x_pos=635 seven times from 0-0 -> score_left=7, OVER after POINT pause, winner 01, ball_run 0.
REQ-039 OVER, start pulse -> scores 0, winner 00, SERVE, ball_serve pulse; start held high in PLAY -> no effect.
REQ-040 Assert reset_n low mid-POINT with score 3-2 -> all outputs at reset values asynchronously, state IDLE.
